// File: rtl/mux_adc_sequencer.sv
// mux_adc_sequencer
// Steps an analog mux through NUM_CH channels, lets each channel settle, runs one
// serial conversion on the ADC (leading zeros, then data bits MSB first), and
// presents each result with its channel index and a one-cycle valid strobe.
// Every output comes straight from a register; no input reaches an output
// combinationally.

module mux_adc_sequencer #(
  parameter int NUM_CH     = 96,  // channels per frame
  parameter int SETTLE_CYC = 16,  // clocks from a mux change to chip-select falling
  parameter int SCLK_DIV   = 4,   // clocks per SCLK half-period
  parameter int LEAD_ZEROS = 2,   // leading bits per ADC frame, discarded
  parameter int ADC_BITS   = 14,  // data bits per conversion
  parameter int QUIET_CYC  = 8    // clocks with chip-select high after a conversion
) (
  input  logic                clk,
  input  logic                rst,         // asynchronous, active low
  input  logic                enable,
  output logic [6:0]          mux_sel,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_sdo,
  output logic [ADC_BITS-1:0] data,
  output logic [6:0]          data_ch,
  output logic                data_valid,
  output logic                frame_done,
  output logic                busy
);

  localparam int FRAME_BITS = LEAD_ZEROS + ADC_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int DIV_W      = $clog2(SCLK_DIV + 1);
  localparam int WAIT_MAX   = (SETTLE_CYC > QUIET_CYC) ? SETTLE_CYC : QUIET_CYC;
  localparam int WAIT_W     = $clog2(WAIT_MAX + 1);

  localparam logic [6:0]        CH_LAST     = 7'(NUM_CH - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYC - 1);
  localparam logic [WAIT_W-1:0] QUIET_LAST  = WAIT_W'(QUIET_CYC - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_QUIET
  } state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;    // settle / quiet clock counter
  logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;      // clocks within an SCLK half-period
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;      // SCLK periods completed in this frame
  logic [ADC_BITS-1:0] shift_reg, shift_reg_nxt;  // serial input; leading zeros fall off the top

  logic [6:0]          mux_sel_nxt;
  logic                adc_cs_n_nxt;
  logic                adc_sclk_nxt;
  logic [ADC_BITS-1:0] data_nxt;
  logic [6:0]          data_ch_nxt;
  logic                data_valid_nxt;
  logic                frame_done_nxt;
  logic                busy_nxt;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    div_cnt_nxt    = div_cnt;
    bit_cnt_nxt    = bit_cnt;
    shift_reg_nxt  = shift_reg;
    mux_sel_nxt    = mux_sel;
    adc_cs_n_nxt   = adc_cs_n;
    adc_sclk_nxt   = adc_sclk;
    data_nxt       = data;
    data_ch_nxt    = data_ch;
    data_valid_nxt = 1'b0;
    frame_done_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        adc_cs_n_nxt = 1'b1;
        adc_sclk_nxt = 1'b1;
        if (enable) begin
          state_nxt    = ST_SETTLE;
          wait_cnt_nxt = '0;
        end
      end

      ST_SETTLE: begin
        adc_cs_n_nxt = 1'b1;
        adc_sclk_nxt = 1'b1;
        if (wait_cnt == SETTLE_LAST) begin
          // Mux has settled: open the conversion with SCLK low.
          state_nxt    = ST_CONVERT;
          wait_cnt_nxt = '0;
          adc_cs_n_nxt = 1'b0;
          adc_sclk_nxt = 1'b0;
          div_cnt_nxt  = '0;
          bit_cnt_nxt  = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ST_CONVERT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (!adc_sclk) begin
            // This edge drives SCLK high: the ADC's bit is stable, take it.
            adc_sclk_nxt  = 1'b1;
            shift_reg_nxt = {shift_reg[ADC_BITS-2:0], adc_sdo};
          end else if (bit_cnt == BIT_LAST) begin
            // Last high half-period done: publish and move the mux on now so
            // the quiet time also counts toward settling of the next channel.
            state_nxt      = ST_QUIET;
            wait_cnt_nxt   = '0;
            adc_cs_n_nxt   = 1'b1;
            adc_sclk_nxt   = 1'b1;
            data_nxt       = shift_reg;
            data_ch_nxt    = mux_sel;
            data_valid_nxt = 1'b1;
            frame_done_nxt = (mux_sel == CH_LAST);
            mux_sel_nxt    = (mux_sel == CH_LAST) ? 7'd0 : mux_sel + 7'd1;
          end else begin
            bit_cnt_nxt  = bit_cnt + 1'b1;
            adc_sclk_nxt = 1'b0;
          end
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end

      ST_QUIET: begin
        adc_cs_n_nxt = 1'b1;
        adc_sclk_nxt = 1'b1;
        if (wait_cnt == QUIET_LAST) begin
          wait_cnt_nxt = '0;
          state_nxt    = enable ? ST_SETTLE : ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      mux_sel    <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_reg_nxt;
      mux_sel    <= mux_sel_nxt;
      adc_cs_n   <= adc_cs_n_nxt;
      adc_sclk   <= adc_sclk_nxt;
      data       <= data_nxt;
      data_ch    <= data_ch_nxt;
      data_valid <= data_valid_nxt;
      frame_done <= frame_done_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mux_adc_sequencer.sv
// Bench for mux_adc_sequencer: an ADC model answers each conversion with a value
// chosen per channel, a scoreboard predicts the result stream from the channel
// order alone, and a serial-timing monitor measures every chip-select window.

module tb_mux_adc_sequencer;

  localparam int NUM_CH    = 96;
  localparam int CONV_CYC  = 128;
  localparam int CH_PERIOD = 152;
  localparam int FIRST_LAT = 16 + 128 + 1;  // negedges from enable to data_valid

  logic        clk;
  logic        rst;
  logic        enable;
  logic [6:0]  mux_sel;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdo;
  logic [13:0] data;
  logic [6:0]  data_ch;
  logic        data_valid;
  logic        frame_done;
  logic        busy;

  mux_adc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mux_sel    (mux_sel),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_sdo    (adc_sdo),
    .data       (data),
    .data_ch    (data_ch),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ADC value source: 0 = constant, 1 = channel*3, 2 = random per channel.
  int          adc_mode = 0;
  logic [13:0] const_val = '0;
  logic [13:0] rand_tab [NUM_CH];

  function automatic logic [13:0] adc_value(input int ch);
    int c;
    c = ch % NUM_CH;
    case (adc_mode)
      0:       return const_val;
      1:       return 14'(c * 3);
      default: return rand_tab[c];
    endcase
  endfunction

  // ADC model: holds a 16-bit frame {00, value} picked for the addressed channel,
  // presents bit 15 once chip-select is low and the next bit after each SCLK rise.
  initial begin : adc_model
    logic [15:0] word;
    int          rises;
    logic        prev_sclk;
    adc_sdo   = 1'b0;
    word      = '0;
    rises     = 0;
    prev_sclk = 1'b1;
    forever begin
      @(negedge clk);
      if (adc_cs_n !== 1'b0) begin
        rises     = 0;
        prev_sclk = 1'b1;
        word      = {2'b00, adc_value(int'(mux_sel))};
      end else begin
        if (adc_sclk && !prev_sclk) rises++;
        prev_sclk = adc_sclk;
      end
      adc_sdo = (rises < 16) ? word[15 - rises] : 1'b0;
    end
  end

  // Scoreboard and serial-timing monitor.
  int   model_ch = 0;
  int   stray_fd = 0;
  int   sclk_idle_bad = 0;
  logic prev_valid = 1'b0;

  initial begin : monitor
    int   win_low, win_rises, run_len, run_min, run_max;
    logic in_win, win_prev_sclk;
    in_win = 1'b0;
    win_low = 0; win_rises = 0; run_len = 0; run_min = 0; run_max = 0;
    win_prev_sclk = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_ch   = 0;
        prev_valid = 1'b0;
        in_win     = 1'b0;
        continue;
      end
      if (frame_done && !data_valid) stray_fd++;
      if (data_valid) begin
        check("sb_one_cycle", prev_valid, 1'b0);
        check("sb_data", data, adc_value(model_ch));
        check("sb_data_ch", data_ch, model_ch);
        check("sb_frame_done", frame_done, model_ch == NUM_CH - 1);
        model_ch = (model_ch + 1) % NUM_CH;
      end
      prev_valid = data_valid;

      if (adc_cs_n) begin
        if (!adc_sclk) sclk_idle_bad++;
        if (in_win) begin
          if (run_len < run_min) run_min = run_len;
          if (run_len > run_max) run_max = run_len;
          check("win_cs_low_clks", win_low, CONV_CYC);
          check("win_sclk_rises", win_rises, 16);
          check("win_half_period", {run_min[15:0], run_max[15:0]}, {16'd4, 16'd4});
          in_win = 1'b0;
        end
      end else begin
        if (!in_win) begin
          in_win = 1'b1;
          win_low = 0; win_rises = 0; run_len = 0;
          run_min = 1 << 20; run_max = 0;
        end else if (adc_sclk != win_prev_sclk) begin
          if (adc_sclk) win_rises++;
          if (run_len < run_min) run_min = run_len;
          if (run_len > run_max) run_max = run_len;
          run_len = 0;
        end
        win_low++;
        run_len++;
        win_prev_sclk = adc_sclk;
      end
    end
  end

  // Helpers
  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  // Waits for data_valid; lat is the number of negedges waited.
  task automatic wait_valid(input int budget, input bit drop_enable, output int lat);
    int n = 0;
    lat = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (drop_enable && n == 1) enable = 1'b0;
      if (data_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_convert_on(input logic [6:0] ch, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (mux_sel == ch && !adc_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [13:0] adc_val;  // value the ADC returns; also the expected data
    logic [6:0]  exp_ch;
    logic [6:0]  exp_mux;  // mux_sel in the data_valid cycle
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int lat, n_valid, cyc, fd_count, idle_valids;
    int t_valid [97];
    bit ok;

    vecs[0] = '{adc_val: 14'h2A5C, exp_ch: 7'd0, exp_mux: 7'd1};
    vecs[1] = '{adc_val: 14'h0000, exp_ch: 7'd1, exp_mux: 7'd2};
    vecs[2] = '{adc_val: 14'h3FFF, exp_ch: 7'd2, exp_mux: 7'd3};
    vecs[3] = '{adc_val: 14'h1555, exp_ch: 7'd3, exp_mux: 7'd4};
    vecs[4] = '{adc_val: 14'h2AAA, exp_ch: 7'd4, exp_mux: 7'd5};
    vecs[5] = '{adc_val: 14'h0001, exp_ch: 7'd5, exp_mux: 7'd6};
    vecs[6] = '{adc_val: 14'h2000, exp_ch: 7'd6, exp_mux: 7'd7};

    // Reset values
    rst = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mux_sel", mux_sel, 7'd0);
    check("rst_cs_n", adc_cs_n, 1'b1);
    check("rst_sclk", adc_sclk, 1'b1);
    check("rst_data", data, 14'd0);
    check("rst_data_ch", data_ch, 7'd0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_cs_n", adc_cs_n, 1'b1);
    check("idle_sclk", adc_sclk, 1'b1);
    check("idle_mux_sel", mux_sel, 7'd0);

    // Single-channel conversions from a table
    adc_mode = 0;
    for (int i = 0; i < 7; i++) begin
      const_val = vecs[i].adc_val;
      @(negedge clk); #1 enable = 1'b1;
      wait_valid(400, 1'b1, lat);
      check("vec_valid_seen", data_valid, 1'b1);
      check("vec_latency", lat, FIRST_LAT);
      check("vec_data", data, vecs[i].adc_val);
      check("vec_data_ch", data_ch, vecs[i].exp_ch);
      check("vec_mux_sel", mux_sel, vecs[i].exp_mux);
      check("vec_cs_n_high", adc_cs_n, 1'b1);
      check("vec_frame_done", frame_done, 1'b0);
      @(negedge clk);
      check("vec_valid_pulse", data_valid, 1'b0);
      wait_idle(50, "vec_back_to_idle");
      check("vec_data_held", data, vecs[i].adc_val);
    end

    // Full frame plus one: wrap and frame_done
    do_reset();
    adc_mode = 1;
    @(negedge clk); #1 enable = 1'b1;
    n_valid = 0; cyc = 0; fd_count = 0;
    while (n_valid < 97 && cyc < 97 * CH_PERIOD + 400) begin
      @(negedge clk);
      cyc++;
      if (frame_done) fd_count++;
      if (data_valid) begin
        t_valid[n_valid] = cyc;
        if (n_valid == 95) begin
          check("frame_last_data", data, 14'd285);
          check("frame_last_ch", data_ch, 7'd95);
          check("frame_last_fd", frame_done, 1'b1);
          check("frame_wrap_mux", mux_sel, 7'd0);
        end
        if (n_valid == 96) begin
          check("frame_next_data", data, 14'd0);
          check("frame_next_ch", data_ch, 7'd0);
          check("frame_next_fd", frame_done, 1'b0);
          check("frame_next_mux", mux_sel, 7'd1);
          enable = 1'b0;
        end
        n_valid++;
      end
    end
    check("frame_result_count", n_valid, 97);
    check("frame_fd_count", fd_count, 1);
    check("frame_period", (n_valid == 97) ? t_valid[96] - t_valid[0] : -1, 96 * CH_PERIOD);
    wait_idle(200, "frame_back_to_idle");

    // Enable dropped mid-conversion on channel 5
    do_reset();
    adc_mode = 1;
    @(negedge clk); #1 enable = 1'b1;
    wait_convert_on(7'd5, 6 * CH_PERIOD + 100, ok);
    check("drop_reached_ch5", ok, 1'b1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_valid(300, 1'b0, lat);
    check("drop_valid_seen", data_valid, 1'b1);
    check("drop_data_ch", data_ch, 7'd5);
    check("drop_data", data, 14'd15);
    wait_idle(100, "drop_to_idle");
    check("drop_mux_sel", mux_sel, 7'd6);
    idle_valids = 0;
    repeat (200) begin
      @(negedge clk);
      if (data_valid) idle_valids++;
    end
    check("drop_no_more_results", idle_valids, 0);
    check("drop_idle_cs_n", adc_cs_n, 1'b1);
    #1 enable = 1'b1;
    wait_valid(400, 1'b0, lat);
    check("resume_latency", lat, FIRST_LAT);
    check("resume_data_ch", data_ch, 7'd6);
    check("resume_data", data, 14'd18);
    enable = 1'b0;
    wait_idle(100, "resume_to_idle");

    // Random enable pattern and random ADC values, checked by the scoreboard
    for (int c = 0; c < NUM_CH; c++) rand_tab[c] = 14'($urandom);
    adc_mode = 2;
    n_valid = 0;
    for (int s = 0; s < 24; s++) begin
      @(negedge clk);
      enable = (s == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc = (s == 0) ? 200 : $urandom_range(1, 400);
      repeat (cyc) begin
        @(negedge clk);
        if (data_valid) n_valid++;
      end
    end
    enable = 1'b0;
    wait_idle(400, "rand_to_idle");
    check("rand_got_results", n_valid > 0, 1'b1);
    check("rand_mux_next_ch", mux_sel, model_ch);

    // Reset in the middle of channel 40's conversion
    do_reset();
    adc_mode = 1;
    @(negedge clk); #1 enable = 1'b1;
    wait_convert_on(7'd40, 41 * CH_PERIOD + 100, ok);
    check("rstmid_reached_ch40", ok, 1'b1);
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid_cs_n", adc_cs_n, 1'b1);
    check("rstmid_sclk", adc_sclk, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_valid", data_valid, 1'b0);
    check("rstmid_mux_sel", mux_sel, 7'd0);
    idle_valids = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_valid) idle_valids++;
    end
    check("rstmid_no_result", idle_valids, 0);
    adc_mode = 0;
    const_val = 14'h1234;
    #1 rst = 1'b1;
    wait_valid(400, 1'b0, lat);
    check("rstmid_after_latency", lat, FIRST_LAT);
    check("rstmid_after_ch", data_ch, 7'd0);
    check("rstmid_after_data", data, 14'h1234);
    enable = 1'b0;
    wait_idle(100, "rstmid_to_idle");

    check("no_stray_frame_done", stray_fd, 0);
    check("sclk_high_while_cs_high", sclk_idle_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
